// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction memory req/ack bus (master = fetch stage, slave = memory)
interface fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRdata;
  modport master(output ImemReq, ImemAddr, input ImemAck, ImemRdata);
  modport slave(input ImemReq, ImemAddr, output ImemAck, ImemRdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage (PC/next-PC, req/ack imem fetch via imem, stall buffer, wrong-path drain; outputs PCF/InstrF/PCPlus4F/ValidF)
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 StallF,
  input  logic                 PCSrcD,
  input  logic [31:0]          PCBranchD,
  input  logic                 JumpD,
  input  logic [31:0]          PCJumpD,
  fetch_stage_if.master        imem,
  output logic [31:0]          PCF,
  output logic [31:0]          InstrF,
  output logic [31:0]          PCPlus4F,
  output logic                 ValidF
);
  typedef enum logic {FETCH, DRAIN} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, stale_q, stale_d, buf_q, buf_d;
  logic        bufv_q, bufv_d;
  logic        fetch, avail, take;
  assign fetch         = state_q == FETCH;
  assign avail         = bufv_q | (fetch & imem.ImemAck);
  assign take          = (PCSrcD | JumpD) & !StallF;
  assign ValidF        = avail & !take;
  assign InstrF        = ValidF ? (bufv_q ? buf_q : imem.ImemRdata) : NOP_INSTR;
  assign PCF           = pc_q;
  assign PCPlus4F      = pc_q + 32'd4;
  assign imem.ImemReq  = fetch ? !bufv_q : 1'b1;
  assign imem.ImemAddr = fetch ? pc_q : stale_q;
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    stale_d = stale_q;
    buf_d   = buf_q;
    bufv_d  = bufv_q;
    if (!fetch && imem.ImemAck) state_d = FETCH;
    if (take) begin
      pc_d   = JumpD ? PCJumpD : PCBranchD;
      bufv_d = 1'b0;
      if (fetch && !avail) begin
        stale_d = pc_q;
        state_d = DRAIN;
      end
    end else if (!StallF) begin
      if (fetch && avail) begin
        pc_d   = PCPlus4F;
        bufv_d = 1'b0;
      end
    end else if (fetch && imem.ImemAck && !bufv_q) begin
      buf_d  = imem.ImemRdata;
      bufv_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= FETCH;
      stale_q <= '0;
      buf_q   <= '0;
      bufv_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      stale_q <= stale_d;
      buf_q   <= buf_d;
      bufv_q  <= bufv_d;
    end
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline; sits directly upstream of the IF/ID register and produces InstrF/PCPlus4F for it.
- Owns the PC register and next-PC selection (sequential, branch, jump).
- Fetches from an instruction memory with variable latency via a req/ack handshake.
- Emits a NOP bubble when no instruction is available, and discards wrong-path or stale responses.
- No branch delay slot.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word emitted for bubbles

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
StallF  in  1  hold PC and fetched instruction (from hazard unit; complement of IF/ID En)
PCSrcD  in  1  branch taken in D
PCBranchD  in  32  branch target
JumpD  in  1  jump / jr in D
PCJumpD  in  32  jump target
ImemReq  out  1  memory request
ImemAddr  out  32  request address, word aligned
ImemAck  in  1  response valid, may be asserted in the same cycle as ImemReq
ImemRdata  in  32  response data, valid with ImemAck
PCF  out  32  current fetch PC
InstrF  out  32  instruction to IF/ID
PCPlus4F  out  32  PCF+4 (mod 2^32) to IF/ID
ValidF  out  1  InstrF holds a real instruction

Behaviour:
- Reset (rst=1 at clk edge):
  - PCF=RESET_PC, state=FETCH, BufValid=0, InstrBuf=0.
  - The memory shares rst, so any outstanding transaction is abandoned.
  - In the cycle after reset, ImemReq=1 and ImemAddr=RESET_PC.
- Registers: PCF; state {FETCH, DRAIN}; StaleAddr; InstrBuf; BufValid.
- Handshake:
  - A transaction completes in any cycle with ImemReq=1 and ImemAck=1.
  - ImemAddr is stable while ImemReq=1 and no ack has arrived.
  - A request is never withdrawn before its ack.
  - ImemAck with ImemReq=0 is ignored.
- Request outputs:
  - FETCH: ImemReq = !BufValid, ImemAddr = PCF.
  - DRAIN: ImemReq = 1, ImemAddr = StaleAddr.
- Instruction availability (combinational):
  - avail = BufValid | (state==FETCH & ImemAck).
  - redirect = PCSrcD | JumpD; JumpD has priority for target selection.
- Outputs (combinational):
  - ValidF = avail & !(redirect & !StallF).
  - InstrF = ValidF ? (BufValid ? InstrBuf : ImemRdata) : NOP_INSTR.
  - PCPlus4F = PCF + 4, wrapping at 2^32.
- Next state, StallF=0, redirect=1:
  - PCF <= target; BufValid <= 0.
  - If state==FETCH, !BufValid and !ImemAck: StaleAddr <= PCF, state <= DRAIN.
  - If state==DRAIN and ImemAck: state <= FETCH.
  - Otherwise state is unchanged.
  - The wrong-path instruction is dropped by forcing NOP.
- Next state, StallF=0, no redirect:
  - FETCH & avail: PCF <= PCF+4, BufValid <= 0.
  - FETCH & !avail: hold PCF; a bubble is emitted.
  - DRAIN: hold PCF; on ImemAck, state <= FETCH. Drained data never appears on InstrF.
- Next state, StallF=1:
  - PCF holds and redirect is ignored (the hazard unit holds PCSrcD/JumpD until the stall clears).
  - FETCH & ImemAck & !BufValid: InstrBuf <= ImemRdata, BufValid <= 1.
  - DRAIN & ImemAck: state <= FETCH.
- Latency: with zero-wait memory, one instruction per cycle. PC after a redirect is visible on PCF the following cycle.
- PCF[1:0] is always 0 when targets are aligned; no alignment checking is performed.

Test Plan:
1. Reset, zero-wait memory returning addr-tagged data, StallF=0 → PCF 0,4,8,…; InstrF=mem[PCF]; ValidF=1 every cycle; PCPlus4F=PCF+4.
2. Memory acks 2 cycles after the request, no stall → ValidF pattern 0,0,1 repeating; InstrF=NOP_INSTR when invalid; PCF advances only on the ack cycle.
3. Zero-wait memory, StallF=1 for 3 cycles with the ack in the first → PCF held; InstrF=buffered word stable across the stall; ImemReq=0 while BufValid; PC+4 on the first unstalled cycle.
4. PCSrcD=1, PCBranchD=0x40 while the request to 0x8 is outstanding (ack 2 cycles later) → same cycle ValidF=0; next cycle PCF=0x40, state DRAIN, ImemAddr=0x8; stale ack discarded; then request 0x40; InstrF=mem[0x40].
5. JumpD=1 and PCSrcD=1 together (targets 0x100 and 0x40) → PCF=0x100; the wrong-path instruction is replaced by NOP_INSTR.
6. PCF=0xFFFF_FFFC → PCPlus4F=0; next PCF=0. rst asserted in DRAIN → next cycle PCF=RESET_PC, state FETCH, ImemAddr=RESET_PC.
